// File: rtl/matrix_tile_scheduler.sv
// Walks the C tile grid of one matrix-multiply job in row-major order and
// issues one per-tile descriptor at a time to the 8x8 MAC-array controller.
module matrix_tile_scheduler #(
  parameter int TILE      = 8,
  parameter int M_TILES_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [14:0]          job_a_base,
  input  logic [16:0]          job_b_base,
  input  logic [14:0]          job_c_base,
  input  logic [14:0]          job_a_line,
  input  logic [16:0]          job_b_line,
  input  logic [14:0]          job_c_line,
  input  logic [11:0]          job_k,
  input  logic [M_TILES_W-1:0] job_m_tiles,
  input  logic [M_TILES_W-1:0] job_n_tiles,
  output logic                 ctrl_valid,
  output logic [14:0]          ctrl_a_addr,
  output logic [16:0]          ctrl_b_addr,
  output logic [14:0]          ctrl_c_addr,
  output logic [14:0]          ctrl_a_line,
  output logic [16:0]          ctrl_b_line,
  output logic [14:0]          ctrl_c_line,
  output logic [11:0]          ctrl_matrix_n,
  input  logic                 req_valid,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

  localparam logic [M_TILES_W-1:0] ONE = {{(M_TILES_W-1){1'b0}}, 1'b1};

  state_t                 state;
  state_t                 state_next;
  logic [M_TILES_W-1:0]   tile_i;
  logic [M_TILES_W-1:0]   tile_j;
  logic [M_TILES_W-1:0]   m_tiles;
  logic [M_TILES_W-1:0]   n_tiles;
  logic [16:0]            b_base;
  logic [14:0]            c_row_base;
  logic [14:0]            c_stride;
  logic                   transfer;
  logic                   last_col;
  logic                   last_row;
  logic                   job_empty;

  always_comb begin
    state_next = state;
    transfer   = (state == ISSUE) && req_valid;
    last_col   = (tile_j == (n_tiles - ONE));
    last_row   = (tile_i == (m_tiles - ONE));
    job_empty  = (job_m_tiles == '0) || (job_n_tiles == '0) || (job_k == 12'd0);
    case (state)
      IDLE: begin
        if (job_valid) begin
          state_next = job_empty ? DONE : ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        if (transfer && last_col && last_row) begin
          state_next = DONE;
        end else begin
          state_next = ISSUE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      job_ready     <= 1'b1;
      ctrl_valid    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      tile_i        <= '0;
      tile_j        <= '0;
      m_tiles       <= '0;
      n_tiles       <= '0;
      b_base        <= 17'd0;
      c_row_base    <= 15'd0;
      c_stride      <= 15'd0;
      ctrl_a_addr   <= 15'd0;
      ctrl_b_addr   <= 17'd0;
      ctrl_c_addr   <= 15'd0;
      ctrl_a_line   <= 15'd0;
      ctrl_b_line   <= 17'd0;
      ctrl_c_line   <= 15'd0;
      ctrl_matrix_n <= 12'd0;
    end else begin
      state      <= state_next;
      job_ready  <= (state_next == IDLE);
      ctrl_valid <= (state_next == ISSUE);
      busy       <= (state_next != IDLE);
      done       <= (state_next == DONE);
      if ((state == IDLE) && job_valid) begin
        tile_i        <= '0;
        tile_j        <= '0;
        m_tiles       <= job_m_tiles;
        n_tiles       <= job_n_tiles;
        b_base        <= job_b_base;
        c_row_base    <= job_c_base;
        c_stride      <= job_c_line << $clog2(TILE);
        ctrl_a_addr   <= job_a_base;
        ctrl_b_addr   <= job_b_base;
        ctrl_c_addr   <= job_c_base;
        ctrl_a_line   <= job_a_line;
        ctrl_b_line   <= job_b_line;
        ctrl_c_line   <= job_c_line;
        ctrl_matrix_n <= job_k;
      end else if (transfer) begin
        // Addresses advance by accumulation; wrap is the natural modulo of each width.
        if (last_col) begin
          tile_j      <= '0;
          ctrl_b_addr <= b_base;
          if (!last_row) begin
            tile_i      <= tile_i + ONE;
            ctrl_a_addr <= ctrl_a_addr + 15'd1;
            c_row_base  <= c_row_base + c_stride;
            ctrl_c_addr <= c_row_base + c_stride;
          end else begin
            tile_i      <= tile_i;
            ctrl_a_addr <= ctrl_a_addr;
            c_row_base  <= c_row_base;
            ctrl_c_addr <= ctrl_c_addr;
          end
        end else begin
          tile_j      <= tile_j + ONE;
          ctrl_b_addr <= ctrl_b_addr + 17'd1;
          ctrl_c_addr <= ctrl_c_addr + 15'd1;
        end
      end else begin
        tile_i <= tile_i;
      end
    end
  end

endmodule

// File: tb/tb_matrix_tile_scheduler.sv
// Randomized self-checking bench for matrix_tile_scheduler; expected tiles
// are computed directly from tile indices with plain arithmetic.
module tb_matrix_tile_scheduler;

  typedef struct {
    logic [14:0] ab;
    logic [16:0] bb;
    logic [14:0] cb;
    logic [14:0] al;
    logic [16:0] bl;
    logic [14:0] cl;
    logic [11:0] k;
    logic [7:0]  m;
    logic [7:0]  n;
  } job_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [14:0] job_a_base = 15'd0;
  logic [16:0] job_b_base = 17'd0;
  logic [14:0] job_c_base = 15'd0;
  logic [14:0] job_a_line = 15'd0;
  logic [16:0] job_b_line = 17'd0;
  logic [14:0] job_c_line = 15'd0;
  logic [11:0] job_k = 12'd0;
  logic [7:0]  job_m_tiles = 8'd0;
  logic [7:0]  job_n_tiles = 8'd0;
  logic        ctrl_valid;
  logic [14:0] ctrl_a_addr;
  logic [16:0] ctrl_b_addr;
  logic [14:0] ctrl_c_addr;
  logic [14:0] ctrl_a_line;
  logic [16:0] ctrl_b_line;
  logic [14:0] ctrl_c_line;
  logic [11:0] ctrl_matrix_n;
  logic        req_valid = 1'b0;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  matrix_tile_scheduler #(.TILE(8), .M_TILES_W(8)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_a_base(job_a_base), .job_b_base(job_b_base), .job_c_base(job_c_base),
    .job_a_line(job_a_line), .job_b_line(job_b_line), .job_c_line(job_c_line),
    .job_k(job_k), .job_m_tiles(job_m_tiles), .job_n_tiles(job_n_tiles),
    .ctrl_valid(ctrl_valid), .ctrl_a_addr(ctrl_a_addr), .ctrl_b_addr(ctrl_b_addr),
    .ctrl_c_addr(ctrl_c_addr), .ctrl_a_line(ctrl_a_line), .ctrl_b_line(ctrl_b_line),
    .ctrl_c_line(ctrl_c_line), .ctrl_matrix_n(ctrl_matrix_n), .req_valid(req_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_job(input job_t jb);
    job_a_base  = jb.ab;
    job_b_base  = jb.bb;
    job_c_base  = jb.cb;
    job_a_line  = jb.al;
    job_b_line  = jb.bl;
    job_c_line  = jb.cl;
    job_k       = jb.k;
    job_m_tiles = jb.m;
    job_n_tiles = jb.n;
  endtask

  // mode: 0 = req always high, 1 = random req, 2 = req pattern 1,0,0 repeating
  task automatic run_job(input job_t jb, input int mode, input bit hold, input job_t nxt,
                         input bit pre, input int abort_at);
    int cnt, idx, cyc, phase, ti, tj;
    logic [14:0] ea, ec;
    logic [16:0] eb;
    bit rv;
    cnt = (jb.m != 8'd0 && jb.n != 8'd0 && jb.k != 12'd0) ? int'(jb.m) * int'(jb.n) : 0;
    if (!pre) begin
      @(negedge clk);
      drive_job(jb);
      job_valid = 1'b1;
    end
    check_val("ready_before_accept", {31'd0, job_ready}, 32'd1);
    @(posedge clk);
    idx = 0; cyc = 0; phase = 0;
    while (idx < cnt && cyc < 4000) begin
      @(negedge clk);
      job_valid = hold;
      if (hold) drive_job(nxt);
      if (idx == abort_at) begin
        rst = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        job_valid = 1'b0;
        check_val("abort_valid", {31'd0, ctrl_valid}, 32'd0);
        check_val("abort_done", {31'd0, done}, 32'd0);
        check_val("abort_ready", {31'd0, job_ready}, 32'd1);
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_c_addr", {17'd0, ctrl_c_addr}, 32'd0);
        @(negedge clk);
        check_val("abort_done2", {31'd0, done}, 32'd0);
        check_val("abort_valid2", {31'd0, ctrl_valid}, 32'd0);
        return;
      end
      ti = idx / int'(jb.n);
      tj = idx % int'(jb.n);
      ea = 15'(int'(jb.ab) + ti);
      eb = 17'(int'(jb.bb) + tj);
      ec = 15'(int'(jb.cb) + ti * 8 * int'(jb.cl) + tj);
      check_val("valid", {31'd0, ctrl_valid}, 32'd1);
      check_val("a_addr", {17'd0, ctrl_a_addr}, {17'd0, ea});
      check_val("b_addr", {15'd0, ctrl_b_addr}, {15'd0, eb});
      check_val("c_addr", {17'd0, ctrl_c_addr}, {17'd0, ec});
      check_val("a_line", {17'd0, ctrl_a_line}, {17'd0, jb.al});
      check_val("b_line", {15'd0, ctrl_b_line}, {15'd0, jb.bl});
      check_val("c_line", {17'd0, ctrl_c_line}, {17'd0, jb.cl});
      check_val("matrix_n", {20'd0, ctrl_matrix_n}, {20'd0, jb.k});
      check_val("busy_issue", {31'd0, busy}, 32'd1);
      check_val("done_issue", {31'd0, done}, 32'd0);
      check_val("ready_issue", {31'd0, job_ready}, 32'd0);
      case (mode)
        0:       rv = 1'b1;
        1:       rv = 1'($urandom_range(0, 1));
        2:       rv = (phase % 3 == 0);
        default: rv = 1'b1;
      endcase
      phase++;
      req_valid = rv;
      if (rv) idx++;
      cyc++;
    end
    check_val("transfer_count", idx, cnt);
    @(negedge clk);
    job_valid = hold;
    req_valid = 1'($urandom_range(0, 1));
    check_val("end_valid", {31'd0, ctrl_valid}, 32'd0);
    check_val("end_done", {31'd0, done}, 32'd1);
    check_val("end_ready", {31'd0, job_ready}, 32'd0);
    check_val("end_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check_val("idle_done", {31'd0, done}, 32'd0);
    check_val("idle_valid", {31'd0, ctrl_valid}, 32'd0);
    check_val("idle_ready", {31'd0, job_ready}, 32'd1);
    check_val("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    job_t ja, jb, jd, jw, jr;
    ja = '{ab: 15'h10, bb: 17'h100, cb: 15'h20, al: 15'h40, bl: 17'h80, cl: 15'd4,
           k: 12'd64, m: 8'd2, n: 8'd3};
    jb = '{ab: 15'h123, bb: 17'h1F000, cb: 15'h300, al: 15'h11, bl: 17'h22, cl: 15'd9,
           k: 12'd7, m: 8'd3, n: 8'd2};

    repeat (2) @(negedge clk);
    check_val("rst_ready", {31'd0, job_ready}, 32'd1);
    check_val("rst_valid", {31'd0, ctrl_valid}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_a_addr", {17'd0, ctrl_a_addr}, 32'd0);
    check_val("rst_b_addr", {15'd0, ctrl_b_addr}, 32'd0);
    check_val("rst_matrix_n", {20'd0, ctrl_matrix_n}, 32'd0);
    rst = 1'b0;

    run_job(ja, 0, 1'b0, ja, 1'b0, -1);
    run_job(ja, 2, 1'b0, ja, 1'b0, -1);
    run_job(ja, 1, 1'b0, ja, 1'b0, -1);

    jd = ja; jd.n = 8'd0;
    run_job(jd, 0, 1'b0, ja, 1'b0, -1);
    jd = ja; jd.k = 12'd0;
    run_job(jd, 0, 1'b0, ja, 1'b0, -1);

    jw = '{ab: 15'h7FFF, bb: 17'h1FFFF, cb: 15'h7FFE, al: 15'd1, bl: 17'd2, cl: 15'h1000,
           k: 12'd8, m: 8'd2, n: 8'd2};
    run_job(jw, 0, 1'b0, ja, 1'b0, -1);

    run_job(ja, 0, 1'b1, jb, 1'b0, -1);
    run_job(jb, 1, 1'b0, ja, 1'b1, -1);

    run_job(ja, 0, 1'b0, ja, 1'b0, 2);
    run_job(ja, 0, 1'b0, ja, 1'b0, -1);

    for (int r = 0; r < 20; r++) begin
      jr.ab = 15'($urandom);
      jr.bb = 17'($urandom);
      jr.cb = 15'($urandom);
      jr.al = 15'($urandom);
      jr.bl = 17'($urandom);
      jr.cl = 15'($urandom);
      jr.k  = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
      jr.m  = 8'($urandom_range(0, 4));
      jr.n  = 8'($urandom_range(0, 4));
      run_job(jr, int'($urandom_range(0, 2)), 1'b0, ja, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
